// File: rtl/bludge_penalty_scheduler.sv
// Penalty sequencer for the four players after a bludger hit.
// Each player runs its own IDLE -> FROZEN -> CLEAN -> IMMUNE -> IDLE FSM with
// a private cycle counter. Hits are queued as pending bits and a round-robin
// arbiter presents them one at a time on the event port. Saturating per-team
// hit counters are kept alongside.
//
// Event port handshake: evt_valid/evt_id are registered. Once evt_valid is
// high, evt_id stays stable until the cycle where evt_valid & evt_ready, which
// is the only cycle an event is consumed. evt_valid does not depend on
// evt_ready. The next pending event, if any, is presented on the very next
// cycle.
module bludge_penalty_scheduler #(
    parameter int FREEZE_CYCLES   = 25000000,
    parameter int IMMUNITY_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_active,
    input  logic [3:0] bludged,
    output logic [3:0] clean,
    output logic [3:0] frozen,
    output logic [3:0] immune,
    output logic       evt_valid,
    output logic [1:0] evt_id,
    input  logic       evt_ready,
    output logic [7:0] hits_blue,
    output logic [7:0] hits_red
);

    // The counter counts 0 .. N-1 for whichever phase is longer.
    localparam int MAX_CYC = (FREEZE_CYCLES > IMMUNITY_CYCLES) ? FREEZE_CYCLES : IMMUNITY_CYCLES;
    localparam int CW      = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] FREEZE_LAST = CW'(FREEZE_CYCLES - 1);
    localparam logic [CW-1:0] IMM_LAST    = CW'(IMMUNITY_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FROZEN = 2'd1,
        ST_CLEAN  = 2'd2,
        ST_IMMUNE = 2'd3
    } state_t;

    state_t          state_q [4];
    state_t          state_d [4];
    logic [CW-1:0]   cnt_q   [4];
    logic [CW-1:0]   cnt_d   [4];
    logic [3:0]      hit_set;

    logic [3:0]      pending_q, pending_d;
    logic [1:0]      ptr_q, ptr_d;
    logic            evt_valid_q, evt_valid_d;
    logic [1:0]      evt_id_q, evt_id_d;
    logic [7:0]      hits_blue_q, hits_blue_d;
    logic [7:0]      hits_red_q, hits_red_d;

    logic            grant;
    logic            hold;
    logic [3:0]      grant_mask;
    logic [1:0]      probe;

    // Add 0..2 hits to a counter, clamping at 255.
    function automatic logic [7:0] sat_add(input logic [7:0] cur, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cur} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Per-player next state and counter; game_active low forces every FSM home.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            hit_set[i] = 1'b0;
            if (!game_active) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (bludged[i]) begin
                            state_d[i] = ST_FROZEN;
                            cnt_d[i]   = '0;
                            hit_set[i] = 1'b1;
                        end
                    end
                    ST_FROZEN: begin
                        if (cnt_q[i] == FREEZE_LAST) begin
                            state_d[i] = ST_CLEAN;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    ST_CLEAN: begin
                        // Wait for the bludger controller to drop the hit flag.
                        if (!bludged[i]) begin
                            state_d[i] = ST_IMMUNE;
                            cnt_d[i]   = '0;
                        end
                    end
                    ST_IMMUNE: begin
                        if (cnt_q[i] == IMM_LAST) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Pending set/clear, pointer update and registered round-robin selection.
    always_comb begin
        grant      = game_active & evt_valid_q & evt_ready;
        hold       = game_active & evt_valid_q & ~evt_ready;
        grant_mask = grant ? (4'b0001 << evt_id_q) : 4'b0000;
        // Set is OR-ed after the clear so a coincident re-hit survives the grant.
        pending_d  = game_active ? ((pending_q & ~grant_mask) | hit_set) : 4'b0000;
        ptr_d      = !game_active ? 2'd0 : (grant ? evt_id_q + 2'd1 : ptr_q);
        probe      = 2'd0;
        evt_id_d   = 2'd0;
        if (hold) begin
            evt_valid_d = 1'b1;
            evt_id_d    = evt_id_q;
        end else begin
            evt_valid_d = |pending_d;
            // Walk from the farthest offset down so the nearest one wins.
            for (int k = 3; k >= 0; k--) begin
                probe = ptr_d + 2'(k);
                if (pending_d[probe]) begin
                    evt_id_d = probe;
                end
            end
        end
        hits_blue_d = sat_add(hits_blue_q, {1'b0, hit_set[0]} + {1'b0, hit_set[1]});
        hits_red_d  = sat_add(hits_red_q,  {1'b0, hit_set[2]} + {1'b0, hit_set[3]});
    end

    // State, counters and arbiter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            pending_q   <= 4'b0000;
            ptr_q       <= 2'd0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= 2'd0;
            hits_blue_q <= 8'd0;
            hits_red_q  <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            hits_blue_q <= hits_blue_d;
            hits_red_q  <= hits_red_d;
        end
    end

    // Outputs are straight decodes of registered state.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            frozen[i] = (state_q[i] == ST_FROZEN);
            clean[i]  = (state_q[i] == ST_CLEAN);
            immune[i] = (state_q[i] == ST_IMMUNE);
        end
        evt_valid = evt_valid_q;
        evt_id    = evt_id_q;
        hits_blue = hits_blue_q;
        hits_red  = hits_red_q;
    end

endmodule

// File: tb/tb_bludge_penalty_scheduler.sv
// Directed bench for bludge_penalty_scheduler with FREEZE_CYCLES=4 and
// IMMUNITY_CYCLES=3. Inputs change just after a falling edge and outputs are
// compared at falling edges, half a cycle away from the active edge.
module tb_bludge_penalty_scheduler;

    logic       clk;
    logic       rst;
    logic       game_active;
    logic [3:0] bludged;
    logic [3:0] clean;
    logic [3:0] frozen;
    logic [3:0] immune;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic [7:0] hits_blue;
    logic [7:0] hits_red;

    int n_cmp;
    int n_err;

    bludge_penalty_scheduler #(
        .FREEZE_CYCLES  (4),
        .IMMUNITY_CYCLES(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .game_active(game_active),
        .bludged    (bludged),
        .clean      (clean),
        .frozen     (frozen),
        .immune     (immune),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .evt_ready  (evt_ready),
        .hits_blue  (hits_blue),
        .hits_red   (hits_red)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        game_active = 1'b0;
        bludged     = 4'b0000;
        evt_ready   = 1'b0;
        repeat (2) step();

        // Reset state.
        check("rst_frozen", 32'(frozen), 32'h0);
        check("rst_clean", 32'(clean), 32'h0);
        check("rst_immune", 32'(immune), 32'h0);
        check("rst_evt_valid", 32'(evt_valid), 32'h0);
        check("rst_hits_blue", 32'(hits_blue), 32'h0);
        check("rst_hits_red", 32'(hits_red), 32'h0);
        rst         = 1'b0;
        game_active = 1'b1;
        evt_ready   = 1'b1;
        step();

        // Single hit on player 0: 4 frozen, clean until release, 3 immune.
        bludged = 4'b0001;
        step();
        check("t1_evt_valid", 32'(evt_valid), 32'h1);
        check("t1_evt_id", 32'(evt_id), 32'h0);
        check("t1_hits_blue", 32'(hits_blue), 32'h1);
        for (int c = 0; c < 4; c++) begin
            check("t1_frozen", 32'(frozen), 32'h1);
            check("t1_clean_low", 32'(clean), 32'h0);
            step();
            if (c == 0) check("t1_evt_once", 32'(evt_valid), 32'h0);
        end
        check("t1_unfrozen", 32'(frozen), 32'h0);
        check("t1_clean", 32'(clean), 32'h1);
        step();
        check("t1_clean_held", 32'(clean), 32'h1);
        bludged = 4'b0000;
        step();
        for (int c = 0; c < 3; c++) begin
            check("t1_immune", 32'(immune), 32'h1);
            check("t1_clean_drop", 32'(clean), 32'h0);
            step();
        end
        check("t1_idle_immune", 32'(immune), 32'h0);
        check("t1_idle_evt", 32'(evt_valid), 32'h0);
        check("t1_hits_blue_end", 32'(hits_blue), 32'h1);

        // All four hit together; a short game_active drop resets the pointer.
        game_active = 1'b0;
        step();
        game_active = 1'b1;
        bludged     = 4'b1111;
        step();
        bludged = 4'b0000;
        check("t2_frozen", 32'(frozen), 32'hF);
        check("t2_hits_blue", 32'(hits_blue), 32'h3);
        check("t2_hits_red", 32'(hits_red), 32'h2);
        for (int c = 0; c < 4; c++) begin
            check("t2_evt_valid", 32'(evt_valid), 32'h1);
            check("t2_evt_id", 32'(evt_id), 32'(c));
            step();
        end
        check("t2_drained", 32'(evt_valid), 32'h0);
        repeat (12) step();

        // Backpressure: id 2 held while player 0 becomes pending, then wrap.
        evt_ready = 1'b0;
        bludged   = 4'b0100;
        step();
        bludged = 4'b0000;
        check("t3_evt_id2", 32'(evt_id), 32'h2);
        step();
        bludged = 4'b0001;
        step();
        bludged = 4'b0000;
        check("t3_frozen", 32'(frozen), 32'h5);
        check("t3_stall_valid", 32'(evt_valid), 32'h1);
        check("t3_stall_id", 32'(evt_id), 32'h2);
        evt_ready = 1'b1;
        step();
        check("t3_next_valid", 32'(evt_valid), 32'h1);
        check("t3_next_id", 32'(evt_id), 32'h0);
        step();
        check("t3_drained", 32'(evt_valid), 32'h0);
        check("t3_hits_blue", 32'(hits_blue), 32'h4);
        check("t3_hits_red", 32'(hits_red), 32'h3);
        repeat (12) step();

        // Player 3 keeps the hit flag up: stuck in CLEAN, then immunity ignores re-hits.
        bludged = 4'b1000;
        step();
        check("t4_frozen", 32'(frozen), 32'h8);
        check("t4_evt_id", 32'(evt_id), 32'h3);
        step();
        repeat (18) step();
        check("t4_clean_stuck", 32'(clean), 32'h8);
        check("t4_not_frozen", 32'(frozen), 32'h0);
        check("t4_no_evt", 32'(evt_valid), 32'h0);
        bludged = 4'b0000;
        step();
        check("t4_immune", 32'(immune), 32'h8);
        check("t4_clean_drop", 32'(clean), 32'h0);
        bludged = 4'b1000;
        step();
        check("t4_immune2", 32'(immune), 32'h8);
        check("t4_rehit_ignored", 32'(evt_valid), 32'h0);
        step();
        check("t4_immune3", 32'(immune), 32'h8);
        bludged = 4'b0000;
        step();
        check("t4_idle_immune", 32'(immune), 32'h0);
        check("t4_idle_frozen", 32'(frozen), 32'h0);
        check("t4_idle_evt", 32'(evt_valid), 32'h0);
        check("t4_hits_red", 32'(hits_red), 32'h4);

        // Abort during freeze with an event stalled.
        evt_ready = 1'b0;
        bludged   = 4'b0010;
        step();
        bludged = 4'b0000;
        check("t5_frozen", 32'(frozen), 32'h2);
        check("t5_evt_valid", 32'(evt_valid), 32'h1);
        check("t5_evt_id", 32'(evt_id), 32'h1);
        check("t5_hits_blue", 32'(hits_blue), 32'h5);
        game_active = 1'b0;
        step();
        check("t5_abort_frozen", 32'(frozen), 32'h0);
        check("t5_abort_evt", 32'(evt_valid), 32'h0);
        check("t5_abort_clean", 32'(clean), 32'h0);
        check("t5_keep_hits", 32'(hits_blue), 32'h5);
        game_active = 1'b1;
        evt_ready   = 1'b1;
        step();
        check("t5_no_resurrect", 32'(evt_valid), 32'h0);

        // Saturation: 256 hits on player 0 after a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_cleared", 32'(hits_blue), 32'h0);
        for (int h = 0; h < 256; h++) begin
            bludged = 4'b0001;
            step();
            bludged     = 4'b0000;
            game_active = 1'b0;
            step();
            game_active = 1'b1;
            if (h == 253) check("t6_at_254", 32'(hits_blue), 32'd254);
        end
        check("t6_sat_blue", 32'(hits_blue), 32'd255);
        check("t6_red_zero", 32'(hits_red), 32'h0);
        bludged = 4'b0011;
        step();
        bludged = 4'b0000;
        check("t6_sat_double", 32'(hits_blue), 32'd255);
        check("t6_double_frozen", 32'(frozen), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
